// File: rtl/tile_pkg.sv
// Shared constants for the tile renderer: glyph codes, shape decode, 4x4 patterns
// (2 bits per pixel, pixel 0 in the LSBs, row-major) and palette reset contents.
package tile_pkg;

  // Stages beyond the memory read: S0 address register, S1 glyph lookup, S2 palette
  localparam int PIPE_FIXED_LAT = 3;

  localparam logic [15:0] G_SOLID_B     = 16'd1;
  localparam logic [15:0] G_SOLID_Y     = 16'd2;
  localparam logic [15:0] G_HPATH_B     = 16'd3;
  localparam logic [15:0] G_RU_B        = 16'd9;
  localparam logic [15:0] G_BIKEH_B     = 16'd11;
  localparam logic [15:0] G_BIKEH_B_END = 16'd19;
  localparam logic [15:0] G_BIKEV_B     = 16'd21;
  localparam logic [15:0] G_BIKEV_B_END = 16'd29;
  localparam logic [15:0] G_HPATH_Y     = 16'd34;
  localparam logic [15:0] G_RU_Y        = 16'd40;
  localparam logic [15:0] G_BIKEH_Y     = 16'd41;
  localparam logic [15:0] G_BIKEH_Y_END = 16'd49;
  localparam logic [15:0] G_BIKEV_Y     = 16'd51;
  localparam logic [15:0] G_BIKEV_Y_END = 16'd59;

  typedef enum logic [3:0] {
    SH_NONE, SH_SOLID, SH_HPATH, SH_VPATH, SH_CORNER,
    SH_LD, SH_LU, SH_RD, SH_RU, SH_BIKEH, SH_BIKEV
  } shape_e;

  typedef struct packed {
    logic   family;
    shape_e shape;
  } glyphDec_t;

  // LU flips LD vertically, RD flips it horizontally, RU flips both
  localparam logic [31:0] PAT_SOLID  = 32'hFFFF_FFFF;
  localparam logic [31:0] PAT_HPATH  = 32'h55AA_AA55;
  localparam logic [31:0] PAT_VPATH  = 32'h6969_6969;
  localparam logic [31:0] PAT_CORNER = 32'h5569_6955;
  localparam logic [31:0] PAT_LD     = 32'h696A_6A55;
  localparam logic [31:0] PAT_LU     = 32'h556A_6A69;
  localparam logic [31:0] PAT_RD     = 32'h69A9_A955;
  localparam logic [31:0] PAT_RU     = 32'h55A9_A969;
  localparam logic [31:0] PAT_BIKEH  = 32'h55FF_FF55;
  localparam logic [31:0] PAT_BIKEV  = 32'h7D7D_7D7D;

  localparam logic [7:0][23:0] PAL_RST = {
    24'hFFFF00, 24'hFFF59C, 24'hE6C800, 24'h000000,
    24'h0000FF, 24'h9CDBE6, 24'h00A2E6, 24'h000000
  };

  function automatic glyphDec_t decodeGlyph(input logic [15:0] code);
    glyphDec_t d;
    d = '{family: 1'b0, shape: SH_NONE};
    if (code == G_SOLID_B)                                  d = '{family: 1'b0, shape: SH_SOLID};
    else if (code == G_SOLID_Y)                             d = '{family: 1'b1, shape: SH_SOLID};
    else if (code >= G_HPATH_B && code <= G_RU_B)           d = '{family: 1'b0, shape: shape_e'(4'(code - 16'd1))};
    else if (code >= G_BIKEH_B && code <= G_BIKEH_B_END)    d = '{family: 1'b0, shape: SH_BIKEH};
    else if (code >= G_BIKEV_B && code <= G_BIKEV_B_END)    d = '{family: 1'b0, shape: SH_BIKEV};
    else if (code >= G_HPATH_Y && code <= G_RU_Y)           d = '{family: 1'b1, shape: shape_e'(4'(code - 16'd32))};
    else if (code >= G_BIKEH_Y && code <= G_BIKEH_Y_END)    d = '{family: 1'b1, shape: SH_BIKEH};
    else if (code >= G_BIKEV_Y && code <= G_BIKEV_Y_END)    d = '{family: 1'b1, shape: SH_BIKEV};
    return d;
  endfunction

  function automatic logic [31:0] patternOf(input shape_e s);
    case (s)
      SH_SOLID:  return PAT_SOLID;
      SH_HPATH:  return PAT_HPATH;
      SH_VPATH:  return PAT_VPATH;
      SH_CORNER: return PAT_CORNER;
      SH_LD:     return PAT_LD;
      SH_LU:     return PAT_LU;
      SH_RD:     return PAT_RD;
      SH_RU:     return PAT_RU;
      SH_BIKEH:  return PAT_BIKEH;
      SH_BIKEV:  return PAT_BIKEV;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// Combinational glyph lookup: glyph code and 4x4 pixel offset to palette family and colour index.
module glyph_rom
  import tile_pkg::*;
(
  input  logic [15:0] code,
  input  logic [3:0]  px,
  output logic        family,
  output logic [1:0]  index
);

  glyphDec_t   dec;
  logic [31:0] pat;

  always_comb begin
    dec    = decodeGlyph(code);
    pat    = patternOf(dec.shape);
    family = dec.family;
    index  = pat[{px, 1'b0} +: 2];
  end

endmodule

// File: rtl/tile_renderer.sv
// Pipelined tile renderer: frame-buffer glyph fetch, 4x4 pattern expansion,
// runtime palette and accent blinking, one pixel per clock.
module tile_renderer
  import tile_pkg::*;
#(
  parameter int TILE_BITS     = 2,
  parameter int TILES_PER_ROW = 160,
  parameter int FB_BASE       = 40000,
  parameter int ADDR_W        = 16,
  parameter int MEM_LATENCY   = 1,
  parameter int BLINK_SHIFT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bright,
  input  logic [15:0]       hCount,
  input  logic [15:0]       vCount,
  output logic [ADDR_W-1:0] memAddress,
  input  logic [15:0]       memData,
  input  logic              pal_we,
  input  logic [2:0]        pal_addr,
  input  logic [23:0]       pal_data,
  input  logic              blink_en,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  // vldPipe[0] is S0, [1..MEM_LATENCY] ride alongside the memory read, [STAGES] is S1
  localparam int STAGES = MEM_LATENCY + PIPE_FIXED_LAT - 2;

  logic [STAGES:0]           vldPipe;
  logic [MEM_LATENCY:0][3:0] pxPipe;
  logic [ADDR_W-1:0]         addrNext;
  logic [3:0]                pxNext;
  logic                      origin, originQ;
  logic [7:0]                frameCnt;
  logic                      romFam, famS1;
  logic [1:0]                romIdx, idxBlk, idxS1;
  logic [7:0][23:0]          pal;

  assign addrNext = ADDR_W'(FB_BASE) + ADDR_W'(hCount >> TILE_BITS)
                  + ADDR_W'(vCount >> TILE_BITS) * ADDR_W'(TILES_PER_ROW);
  assign pxNext   = {vCount[TILE_BITS-1 -: 2], hCount[TILE_BITS-1 -: 2]};
  assign origin   = (hCount == 16'd0) && (vCount == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      memAddress <= '0;
      vldPipe    <= '0;
    end else begin
      memAddress <= addrNext;
      vldPipe    <= {vldPipe[STAGES-1:0], bright};
    end
  end

  always_ff @(posedge clk)
    pxPipe <= {pxPipe[MEM_LATENCY-1:0], pxNext};

  // originQ resets high so an origin held across reset is not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      originQ  <= 1'b1;
      frameCnt <= '0;
    end else begin
      originQ <= origin;
      if (origin && !originQ) frameCnt <= frameCnt + 8'd1;
    end
  end

  glyph_rom glyphRom (
    .code   (memData),
    .px     (pxPipe[MEM_LATENCY]),
    .family (romFam),
    .index  (romIdx)
  );

  always_comb begin
    idxBlk = romIdx;
    if (blink_en && frameCnt[BLINK_SHIFT] && romIdx == 2'd3) idxBlk = 2'd2;
  end

  always_ff @(posedge clk) begin
    famS1 <= romFam;
    idxS1 <= idxBlk;
  end

  // No write-to-read bypass: a same-edge S2 read sees the old entry
  always_ff @(posedge clk) begin
    if (reset)       pal <= PAL_RST;
    else if (pal_we) pal[pal_addr] <= pal_data;
  end

  always_ff @(posedge clk) begin
    if (reset) {VGA_R, VGA_G, VGA_B} <= '0;
    else       {VGA_R, VGA_G, VGA_B} <= vldPipe[STAGES] ? pal[{famS1, idxS1}] : 24'h0;
  end

endmodule
